// File: rtl/heater_pkg.sv
// Shared types and helpers for the heater soft-start sequencer.
package heater_pkg;

  localparam int unsigned ERR_CNT_W = 8;
  localparam int unsigned CNT_MAX_W = 7;

  typedef enum logic [2:0] {
    IDLE,
    RAMP_UP,
    HOLD,
    RAMP_DOWN,
    FAULT
  } state_e;

  // One bit of a thermometer code: bit idx is set when fewer than count bits lie below it.
  function automatic logic therm_bit(input logic [CNT_MAX_W-1:0] count,
                                     input logic [CNT_MAX_W-1:0] idx);
    return idx < count;
  endfunction

endpackage

// File: rtl/heater_err_monitor.sv
// Per-heater error edge detection, sticky flags, clear pulses and saturating event count.
module heater_err_monitor
  import heater_pkg::*;
#(
  parameter int unsigned N = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         heater_error,
  input  logic [N-1:0]         heater_enable,
  input  logic                 suppress_clear,
  input  logic                 clear_all,
  output logic [N-1:0]         heater_err_clear,
  output logic [N-1:0]         error_sticky,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int unsigned PW = $clog2(N + 1);
  localparam int unsigned SW = ERR_CNT_W + 1;

  logic [N-1:0]         err_prev_q, err_prev_d;
  logic [N-1:0]         clear_q, clear_d;
  logic [N-1:0]         sticky_q, sticky_d;
  logic [ERR_CNT_W-1:0] count_q, count_d;
  logic [N-1:0]         err_event_c;
  logic [PW-1:0]        pop_c;
  logic [SW-1:0]        sum_c;

  // Rising error edges on enabled heaters, their popcount and the next accumulator state.
  always_comb begin
    err_event_c = heater_error & ~err_prev_q & heater_enable;
    pop_c       = '0;
    for (int i = 0; i < N; i++) begin
      pop_c = pop_c + PW'(err_event_c[i]);
    end
    sum_c      = SW'(count_q) + SW'(pop_c);
    err_prev_d = heater_error;
    clear_d    = suppress_clear ? '0 : err_event_c;
    sticky_d   = sticky_q | err_event_c;
    count_d    = sum_c[SW-1] ? '1 : ERR_CNT_W'(sum_c);
    if (clear_all) begin
      clear_d  = '1;
      sticky_d = '0;
      count_d  = '0;
    end
  end

  // Monitor state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_prev_q <= '0;
      clear_q    <= '0;
      sticky_q   <= '0;
      count_q    <= '0;
    end else begin
      err_prev_q <= err_prev_d;
      clear_q    <= clear_d;
      sticky_q   <= sticky_d;
      count_q    <= count_d;
    end
  end

  assign heater_err_clear = clear_q;
  assign error_sticky     = sticky_q;
  assign err_count        = count_q;

endmodule

// File: rtl/heater_sequencer.sv
// Soft-start sequencer: steps heater enables up/down at a fixed interval, faults on excess errors.
module heater_sequencer
  import heater_pkg::*;
#(
  parameter int unsigned N           = 32,
  parameter int unsigned STEP_CYCLES = 300000,
  parameter int unsigned ERR_LIMIT   = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     stop,
  input  logic [$clog2(N+1)-1:0]   target_count,
  input  logic                     fault_clear,
  input  logic [N-1:0]             heater_error,
  output logic [N-1:0]             heater_enable,
  output logic [N-1:0]             heater_err_clear,
  output logic [$clog2(N+1)-1:0]   active_count,
  output logic [N-1:0]             error_sticky,
  output logic [ERR_CNT_W-1:0]     err_count,
  output logic                     fault,
  output logic                     busy
);

  localparam int unsigned CW = $clog2(N + 1);
  localparam int unsigned TW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [TW-1:0]        TIMER_RELOAD = TW'(STEP_CYCLES - 1);
  localparam logic [CW-1:0]        N_CNT        = CW'(N);
  localparam logic [ERR_CNT_W-1:0] ERR_LIM      = ERR_CNT_W'(ERR_LIMIT);

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [CW-1:0] active_q, active_d;
  logic [N-1:0]  enable_q, enable_d;
  logic          fault_q, fault_d;
  logic          busy_q, busy_d;
  logic [CW-1:0] target_c;
  logic [CW-1:0] step_cnt_c;
  logic          run_c;
  logic          fault_clr_c;

  assign target_c = (target_count > N_CNT) ? N_CNT : target_count;
  assign run_c    = start && !stop;

  // Next state, step timer and enabled-heater count.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    active_d    = active_q;
    step_cnt_c  = active_q;
    fault_clr_c = 1'b0;
    if (state_q != FAULT && err_count >= ERR_LIM) begin
      state_d  = FAULT;
      active_d = '0;
      timer_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          active_d = '0;
          if (run_c && target_c != '0) begin
            state_d = RAMP_UP;
            timer_d = TIMER_RELOAD;
          end
        end
        RAMP_UP: begin
          if (!run_c || target_c < active_q) begin
            state_d = (active_q == '0) ? IDLE : RAMP_DOWN;
            timer_d = TIMER_RELOAD;
          end else if (active_q == target_c) begin
            state_d = (active_q == '0) ? IDLE : HOLD;
          end else if (timer_q == '0) begin
            step_cnt_c = active_q + CW'(1);
            active_d   = step_cnt_c;
            timer_d    = TIMER_RELOAD;
            if (step_cnt_c == target_c) state_d = HOLD;
          end else begin
            timer_d = timer_q - TW'(1);
          end
        end
        HOLD: begin
          if (!run_c || target_c < active_q) begin
            state_d = RAMP_DOWN;
            timer_d = TIMER_RELOAD;
          end else if (target_c > active_q) begin
            state_d = RAMP_UP;
            timer_d = TIMER_RELOAD;
          end
        end
        RAMP_DOWN: begin
          if (active_q == '0) begin
            state_d = IDLE;
          end else if (run_c && target_c > active_q) begin
            state_d = RAMP_UP;
            timer_d = TIMER_RELOAD;
          end else if (run_c && target_c == active_q) begin
            state_d = HOLD;
          end else if (timer_q == '0) begin
            step_cnt_c = active_q - CW'(1);
            active_d   = step_cnt_c;
            timer_d    = TIMER_RELOAD;
            if (step_cnt_c == '0) state_d = IDLE;
            else if (run_c && target_c == step_cnt_c) state_d = HOLD;
          end else begin
            timer_d = timer_q - TW'(1);
          end
        end
        FAULT: begin
          active_d = '0;
          if (fault_clear) begin
            state_d     = IDLE;
            fault_clr_c = 1'b1;
          end
        end
        default: begin
          state_d  = IDLE;
          active_d = '0;
        end
      endcase
    end
    for (int i = 0; i < N; i++) begin
      enable_d[i] = therm_bit(CNT_MAX_W'(active_d), CNT_MAX_W'(i));
    end
    fault_d = (state_d == FAULT);
    busy_d  = (state_d == RAMP_UP) || (state_d == RAMP_DOWN);
  end

  // FSM and output registers; reset drops every enable at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      active_q <= '0;
      enable_q <= '0;
      fault_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      active_q <= active_d;
      enable_q <= enable_d;
      fault_q  <= fault_d;
      busy_q   <= busy_d;
    end
  end

  heater_err_monitor #(
    .N(N)
  ) u_err_monitor (
    .clk             (clk),
    .rst_n           (rst_n),
    .heater_error    (heater_error),
    .heater_enable   (enable_q),
    .suppress_clear  (state_q == FAULT),
    .clear_all       (fault_clr_c),
    .heater_err_clear(heater_err_clear),
    .error_sticky    (error_sticky),
    .err_count       (err_count)
  );

  assign heater_enable = enable_q;
  assign active_count  = active_q;
  assign fault         = fault_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_heater_sequencer.sv
// Scoreboard bench for heater_sequencer (N=4, STEP_CYCLES=4, ERR_LIMIT=3).
module tb_heater_sequencer;

  localparam int unsigned N = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic [2:0]   target_count = '0;
  logic         fault_clear = 1'b0;
  logic [N-1:0] heater_error = '0;
  logic [N-1:0] heater_enable;
  logic [N-1:0] heater_err_clear;
  logic [2:0]   active_count;
  logic [N-1:0] error_sticky;
  logic [7:0]   err_count;
  logic         fault;
  logic         busy;

  heater_sequencer #(
    .N(N),
    .STEP_CYCLES(4),
    .ERR_LIMIT(3)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .stop            (stop),
    .target_count    (target_count),
    .fault_clear     (fault_clear),
    .heater_error    (heater_error),
    .heater_enable   (heater_enable),
    .heater_err_clear(heater_err_clear),
    .active_count    (active_count),
    .error_sticky    (error_sticky),
    .err_count       (err_count),
    .fault           (fault),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [N-1:0] val;
    int           at;
  } exp_t;

  exp_t         en_q[$];
  exp_t         clr_q[$];
  int           checks = 0;
  int           errors = 0;
  int           base = 0;
  logic [N-1:0] last_en = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_en(input logic [N-1:0] v, input int at);
    exp_t e;
    e.val = v;
    e.at  = at;
    en_q.push_back(e);
  endtask

  task automatic push_clr(input logic [N-1:0] v, input int at);
    exp_t e;
    e.val = v;
    e.at  = at;
    clr_q.push_back(e);
  endtask

  // Monitor: every enable change and every clear pulse must match the next queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (heater_enable !== last_en) begin
      last_en = heater_enable;
      checks++;
      if (en_q.size() == 0) begin
        errors++;
        $display("FAIL enable_change: got %b at cycle %0d, no change expected", heater_enable, cyc);
      end else begin
        e = en_q.pop_front();
        if (heater_enable !== e.val || (e.at >= 0 && cyc != e.at)) begin
          errors++;
          $display("FAIL enable_step: got %b at cycle %0d, expected %b at cycle %0d",
                   heater_enable, cyc, e.val, e.at);
        end
      end
    end
    if (heater_err_clear !== '0) begin
      checks++;
      if (clr_q.size() == 0) begin
        errors++;
        $display("FAIL err_clear_pulse: got %b at cycle %0d, no pulse expected", heater_err_clear, cyc);
      end else begin
        e = clr_q.pop_front();
        if (heater_err_clear !== e.val || cyc != e.at) begin
          errors++;
          $display("FAIL err_clear_pulse: got %b at cycle %0d, expected %b at cycle %0d",
                   heater_err_clear, cyc, e.val, e.at);
        end
      end
    end
  end

  initial begin
    // Reset state
    tick(3);
    chk("reset_enable", 32'(heater_enable), 32'h0);
    chk("reset_active", 32'(active_count), 32'h0);
    chk("reset_fault", 32'(fault), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_err_count", 32'(err_count), 32'h0);
    chk("reset_clear", 32'(heater_err_clear), 32'h0);
    rst_n = 1'b1;
    tick(2);

    // Ramp up to 3
    start = 1'b1; target_count = 3'd3; base = cyc;
    push_en(4'b0001, base + 5);
    push_en(4'b0011, base + 9);
    push_en(4'b0111, base + 13);
    tick(2);
    chk("ramp_busy", 32'(busy), 32'h1);
    tick(12);
    chk("hold_active3", 32'(active_count), 32'd3);
    chk("hold_busy", 32'(busy), 32'h0);

    // Retarget down to 1, then stop
    target_count = 3'd1; base = cyc;
    push_en(4'b0011, base + 5);
    push_en(4'b0001, base + 9);
    tick(10);
    chk("retarget_active1", 32'(active_count), 32'd1);
    chk("retarget_busy", 32'(busy), 32'h0);
    stop = 1'b1; base = cyc;
    push_en(4'b0000, base + 5);
    tick(6);
    chk("stop_active0", 32'(active_count), 32'd0);
    chk("stop_busy", 32'(busy), 32'h0);
    stop = 1'b0; start = 1'b0;
    tick(2);

    // Fault: two simultaneous errors, then a third
    start = 1'b1; target_count = 3'd3; base = cyc;
    push_en(4'b0001, base + 5);
    push_en(4'b0011, base + 9);
    push_en(4'b0111, base + 13);
    tick(14);
    heater_error = 4'b0011; base = cyc;
    push_clr(4'b0011, base + 1);
    tick(2);
    chk("pair_err_count", 32'(err_count), 32'd2);
    chk("pair_sticky", 32'(error_sticky), 32'h3);
    chk("pair_no_fault", 32'(fault), 32'h0);
    heater_error = 4'b0111; base = cyc;
    push_clr(4'b0100, base + 1);
    push_en(4'b0000, base + 2);
    tick(1);
    chk("third_err_count", 32'(err_count), 32'd3);
    tick(2);
    chk("fault_flag", 32'(fault), 32'h1);
    chk("fault_active", 32'(active_count), 32'd0);
    chk("fault_busy", 32'(busy), 32'h0);
    chk("fault_sticky", 32'(error_sticky), 32'h7);
    start = 1'b0; fault_clear = 1'b1; base = cyc;
    push_clr(4'b1111, base + 1);
    tick(1);
    fault_clear = 1'b0;
    chk("clear_fault_flag", 32'(fault), 32'h0);
    chk("clear_err_count", 32'(err_count), 32'd0);
    chk("clear_sticky", 32'(error_sticky), 32'h0);
    heater_error = '0;
    tick(2);
    chk("clear_idle_busy", 32'(busy), 32'h0);

    // Single error on an enabled heater, then an ignored one on a disabled heater
    start = 1'b1; target_count = 3'd2; base = cyc;
    push_en(4'b0001, base + 5);
    push_en(4'b0011, base + 9);
    tick(10);
    heater_error = 4'b0010; base = cyc;
    push_clr(4'b0010, base + 1);
    tick(2);
    chk("single_err_count", 32'(err_count), 32'd1);
    chk("single_sticky", 32'(error_sticky), 32'h2);
    chk("single_active", 32'(active_count), 32'd2);
    heater_error = 4'b1000;
    tick(2);
    chk("ignored_err_count", 32'(err_count), 32'd1);
    chk("ignored_sticky", 32'(error_sticky), 32'h2);
    heater_error = '0;
    fault_clear = 1'b1;
    tick(1);
    fault_clear = 1'b0;
    tick(1);
    chk("stray_clear_err_count", 32'(err_count), 32'd1);
    chk("stray_clear_fault", 32'(fault), 32'h0);

    // Reset during a ramp, then clamped target
    target_count = 3'd4; base = cyc;
    push_en(4'b0111, base + 5);
    tick(6);
    push_en(4'b0000, -1);
    start = 1'b0; rst_n = 1'b0;
    #1;
    chk("midreset_enable", 32'(heater_enable), 32'h0);
    chk("midreset_active", 32'(active_count), 32'd0);
    chk("midreset_busy", 32'(busy), 32'h0);
    chk("midreset_err_count", 32'(err_count), 32'd0);
    chk("midreset_sticky", 32'(error_sticky), 32'h0);
    tick(2);
    rst_n = 1'b1;
    tick(1);
    start = 1'b1; target_count = 3'd7; base = cyc;
    push_en(4'b0001, base + 5);
    push_en(4'b0011, base + 9);
    push_en(4'b0111, base + 13);
    push_en(4'b1111, base + 17);
    tick(18);
    chk("clamp_active", 32'(active_count), 32'd4);
    chk("clamp_busy", 32'(busy), 32'h0);
    chk("clamp_enable", 32'(heater_enable), 32'hF);
    tick(3);
    chk("enable_queue_drained", 32'(en_q.size()), 32'd0);
    chk("clear_queue_drained", 32'(clr_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
